// File: rtl/evm_pkg.sv
// Shared voter-record definitions: word width, the bit-scramble table and FSM encoding.
// The scrambler and depermute_map both read MAP, so one table defines both directions.
package evm_pkg;

    localparam int WORD_W = 64;
    localparam int IDX_W  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Forward scramble: scr[i] = orig[MAP[i]], bit 0 is the MSB.
    localparam logic [5:0] MAP [0:63] = '{
        6'd43, 6'd25, 6'd19, 6'd29, 6'd53, 6'd36, 6'd58, 6'd51,
        6'd41, 6'd34, 6'd60, 6'd3,  6'd6,  6'd32, 6'd57, 6'd61,
        6'd48, 6'd52, 6'd18, 6'd38, 6'd45, 6'd14, 6'd31, 6'd55,
        6'd16, 6'd9,  6'd0,  6'd44, 6'd49, 6'd42, 6'd54, 6'd30,
        6'd23, 6'd20, 6'd4,  6'd12, 6'd21, 6'd37, 6'd59, 6'd40,
        6'd35, 6'd2,  6'd27, 6'd17, 6'd11, 6'd50, 6'd62, 6'd56,
        6'd47, 6'd13, 6'd7,  6'd1,  6'd22, 6'd26, 6'd33, 6'd10,
        6'd5,  6'd28, 6'd15, 6'd46, 6'd63, 6'd8,  6'd39, 6'd24
    };

    function automatic bit lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) ||
               (lanes == 16) || (lanes == 32) || (lanes == 64);
    endfunction

endpackage

// File: rtl/depermute_map.sv
// Restores original bit order of a scrambled 64-bit voter record, LANES bits per cycle,
// with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a scrambled word, in_ready high
// RUN   | writing LANES restored bits per cycle into data_out
// HOLD  | restored word presented, waiting for out_ready
module depermute_map
    import evm_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic          clk,
    input  logic          set,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:63]   data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:63]   data_out,
    output logic          busy
);

    generate
        if (!lanes_legal(LANES)) begin : g_lanes_illegal
            $fatal(1, "depermute_map: LANES=%0d is not a power of two in 1..64", LANES);
        end
    endgenerate

    // idx value at the start of the final RUN cycle
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - LANES);

    state_e             state_q, state_d;
    logic [0:63]        cap_q, cap_d;
    logic [0:63]        data_q, data_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    always_comb begin
        logic [5:0] pos;
        pos     = '0;
        state_d = state_q;
        cap_d   = cap_q;
        data_d  = data_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cap_d   = data_in;
                    data_d  = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int j = 0; j < LANES; j++) begin
                    pos = idx_q[5:0] + 6'(j);
                    data_d[MAP[pos]] = cap_q[pos];
                end
                idx_d = idx_q + IDX_W'(LANES);
                if (idx_q == LAST_IDX) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (set) begin
            state_q <= IDLE;
            cap_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign data_out  = data_q;

endmodule

// File: tb/tb_depermute_map.sv
// Scoreboard bench for depermute_map: directed vectors, backpressure, mid-RUN reset
// and a scrambled round trip of random words.
module tb_depermute_map;

    localparam int LANES = 8;
    localparam int LAT   = 64 / LANES;

    localparam int TB_MAP [64] = '{
        43, 25, 19, 29, 53, 36, 58, 51,  41, 34, 60, 3,  6,  32, 57, 61,
        48, 52, 18, 38, 45, 14, 31, 55,  16, 9,  0,  44, 49, 42, 54, 30,
        23, 20, 4,  12, 21, 37, 59, 40,  35, 2,  27, 17, 11, 50, 62, 56,
        47, 13, 7,  1,  22, 26, 33, 10,  5,  28, 15, 46, 63, 8,  39, 24
    };

    logic        clk = 1'b0;
    logic        set;
    logic        in_valid;
    logic        in_ready;
    logic [0:63] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] data_out;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
    int          n_in = 0;
    int          n_out = 0;
    logic [0:63] exp_q [$];

    depermute_map #(.LANES(LANES)) dut (
        .clk       (clk),
        .set       (set),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [0:63] scramble(input logic [0:63] orig);
        logic [0:63] s;
        for (int i = 0; i < 64; i++) s[i] = orig[TB_MAP[i]];
        return s;
    endfunction

    // out_ready driver
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // monitor: a transfer happens at the next posedge when valid&&ready at negedge
    initial begin
        forever begin
            @(negedge clk);
            if (!set && out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", data_out, 64'hx);
                end else begin
                    chk("data_out", data_out, exp_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+#1; returns at accept posedge+#1 with in_valid dropped.
    task automatic send(input logic [0:63] w, input logic [0:63] exp);
        bit done = 0;
        in_valid = 1'b1;
        data_in  = w;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                n_in++;
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic latency_check(input string name);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 64'(n), 64'(LAT));
    endtask

    initial begin
        logic [0:63] w;
        set      = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        set = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data_out", data_out, 64'h0);

        // single MSB -> bit 43, with latency
        ready_mode = 1;
        send(64'h8000_0000_0000_0000, 64'h0000_0000_0010_0000);
        chk("busy_in_run", 64'(busy), 64'd1);
        latency_check("latency_first");
        wait_drain();

        // LSB -> bit 24
        send(64'h0000_0000_0000_0001, 64'h0000_0080_0000_0000);
        latency_check("latency_last");
        wait_drain();
        send(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000);
        wait_drain();
        chk("hold_result_between_words", data_out, 64'h0);

        // all ones under 20 cycles of backpressure
        ready_mode = 0;
        @(posedge clk); #1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        latency_check("latency_ones");
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c % 5 == 0) begin
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_data_out", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        ready_mode = 1;
        wait_drain();

        // reset during the 4th RUN cycle
        ready_mode = 0;
        @(posedge clk); #1;
        send(64'hDEAD_BEEF_0123_4567, 64'h0);
        repeat (3) begin @(posedge clk); #1; end
        set = 1'b1;
        in_valid = 1'b1;
        data_in = 64'h8000_0000_0000_0000;
        @(posedge clk); #1;
        set = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        n_in--;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_data_out", data_out, 64'h0);
        @(posedge clk); #1;
        chk("set_blocks_capture", 64'(busy), 64'd0);
        ready_mode = 1;
        send(64'h0000_0000_0000_0001, 64'h0000_0080_0000_0000);
        wait_drain();

        // round trip with random backpressure
        ready_mode = 2;
        for (int k = 0; k < 1000; k++) begin
            w = {$urandom, $urandom};
            send(scramble(w), w);
        end
        ready_mode = 1;
        wait_drain();
        chk("word_count", 64'(n_out), 64'(n_in));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/depermute_map.md
# depermute_map

Inverse of the 64-bit voter-record bit scrambler: takes a scrambled 64-bit word and restores the original bit order by applying the inverse of the fixed 64-entry permutation table. The work is iterative, LANES bits per cycle, behind valid/ready handshakes on both sides. It sits on the readback/tally path, downstream of record storage, so every scrambled record can be recovered bit-exact.

## Interface
Parameters:
- LANES, 8, bits de-permuted per RUN cycle; legal values 1, 2, 4, 8, 16, 32, 64.

Ports:
- clk  in  1  rising-edge clock
- set  in  1  synchronous, active-high reset; clears all state
- in_valid  in  1  data_in holds a scrambled word
- in_ready  out  1  block can accept a word
- data_in  in  [0:63]  scrambled word; bit 0 is the MSB
- out_valid  out  1  data_out holds a complete restored word
- out_ready  in  1  consumer accepts data_out
- data_out  out  [0:63]  restored word; bit 0 is the MSB
- busy  out  1  high in RUN and HOLD

## Operation
- Forward table MAP[0..63] = 43,25,19,29,53,36,58,51, 41,34,60,3,6,32,57,61, 48,52,18,38,45,14,31,55, 16,9,0,44,49,42,54,30, 23,20,4,12,21,37,59,40, 35,2,27,17,11,50,62,56, 47,13,7,1,22,26,33,10, 5,28,15,46,63,8,39,24.
- Forward scramble is scr[i] = orig[MAP[i]]. This block computes data_out[MAP[i]] = captured[i] for all i in 0..63.
- States:
  - IDLE: in_ready=1. On in_valid: capture data_in into an internal register, clear data_out to 0 and idx to 0, then go to RUN.
  - RUN: each cycle, for j in 0..LANES-1, data_out[MAP[idx+j]] <= captured[idx+j], then idx += LANES. When idx+LANES == 64, go to HOLD after that cycle's write.
  - HOLD: out_valid=1 and data_out is stable. On out_ready, go to IDLE.
- in_ready is 1 only in IDLE. A new word cannot be accepted in the same cycle as an out_ready completion.
- idx is 7 bits wide and never wraps past 64. The captured word is not modified after capture.
- data_out is meaningful only while out_valid=1. Between words it holds the last completed result until the next accept clears it.
- set has priority over every other input in every state. The next cycle shows IDLE, in_ready=1, out_valid=0, busy=0, data_out=0, and any in-flight word is discarded.
- in_valid with set high in the same cycle: the word is not captured.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, data_out=64'h0. The internal captured word and idx reset to 0.
- Outputs are registered. in_ready, out_valid and busy decode from the registered state.
- Accept happens at the edge where in_valid&&in_ready. RUN then lasts 64/LANES cycles. out_valid rises 64/LANES edges after the accept edge, which is 8 for LANES=8.
- HOLD lasts until out_ready. Re-accept is possible no earlier than 1 cycle after the completion edge.
- Throughput is one word per 64/LANES+2 cycles when out_ready is held at 1.
- out_ready outside HOLD is ignored. in_valid outside IDLE is ignored; the source must hold the word until in_ready.

## Structure
- Shared package evm_pkg holds:
  - WORD_W=64;
  - the MAP table as a constant array of 64 six-bit entries, the same constant used by the forward scrambler so one table defines both directions;
  - the state encoding IDLE/RUN/HOLD.
- No sub-module. A single FSM plus a LANES-wide write loop inside one clocked process.
- LANES legality is checked at elaboration; an illegal value is a fatal error.

## Test plan
- Reset then single bit: hold set 2 cycles, then send 64'h8000_0000_0000_0000. Expect out_valid exactly 8 edges after accept and data_out=64'h0000_0000_0010_0000 (bit 43).
- Last bit: send 64'h0000_0000_0000_0001. Expect data_out=64'h0000_0080_0000_0000 (bit 24).
- Round trip: apply the forward scramble to 1000 random words and feed them in with out_ready random 50%. Every data_out equals its original word, order is preserved, and no word is lost or duplicated.
- Patterns and backpressure: all-ones maps to all-ones and all-zeros maps to all-zeros. Hold out_ready=0 for 20 cycles: data_out and out_valid stay stable and in_ready stays 0.
- Reset mid-RUN: assert set at RUN cycle 4. The next cycle shows in_ready=1, out_valid=0, data_out=0. A following word then completes correctly.
- Parameter sweep: LANES=1 gives latency 64 and LANES=64 gives latency 1, with identical results to the round-trip vectors.
